// File: rtl/delta_sequencer.sv
// Backward-pass delta sequencer: sweeps layers deepest-first, issues one read per neuron,
// captures the generator's delta a cycle later and commits each full layer to d_in.
`ifndef BITWIDTH
`define BITWIDTH 32
`endif
`ifndef MAX_DEPTH
`define MAX_DEPTH 3
`endif

module delta_sequencer #(
  parameter int NEURONS = 4
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                start,
  input  logic [`BITWIDTH-1:0]                d_generated,
  output logic                                read,
  output logic [31:0]                         layer_index,
  output logic [31:0]                         neuron_index,
  output logic [NEURONS-1:0][`BITWIDTH-1:0]   d_in,
  output logic                                layer_valid,
  output logic [31:0]                         valid_layer,
  output logic                                busy,
  output logic                                done
);

  localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]                            state;
  logic                                  read_d;
  logic [IDX_W-1:0]                      idx_d;
  logic [NEURONS-1:0][`BITWIDTH-1:0]     d_layer;

  assign read = (state == ISSUE);
  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      read_d       <= 1'b0;
      idx_d        <= '0;
      d_layer      <= '0;
      d_in         <= '0;
      layer_index  <= '0;
      neuron_index <= '0;
      valid_layer  <= '0;
      layer_valid  <= 1'b0;
      done         <= 1'b0;
    end else begin
      layer_valid <= 1'b0;
      done        <= 1'b0;
      // Generator answers one cycle after the read strobe, so track the issued slot.
      read_d      <= (state == ISSUE);
      idx_d       <= neuron_index[IDX_W-1:0];
      if (read_d) begin
        d_layer[idx_d] <= d_generated;
      end
      case (state)
        IDLE: begin
          if (start) begin
            layer_index  <= 32'(`MAX_DEPTH - 1);
            neuron_index <= '0;
            d_layer      <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (neuron_index == 32'(NEURONS - 1)) begin
            neuron_index <= '0;
            state        <= DRAIN;
          end else begin
            neuron_index <= neuron_index + 32'd1;
          end
        end
        DRAIN: begin
          state <= COMMIT;
        end
        COMMIT: begin
          d_in        <= d_layer;
          valid_layer <= layer_index;
          layer_valid <= 1'b1;
          if (layer_index == 32'd0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            layer_index <= layer_index - 32'd1;
            state       <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
